flash_ctrl: RTL and testbench
=============================

FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, word-address width.
REQ-002 SHALL have parameter READ_WAIT, default 4, clk cycles from OE low to read-data capture (1..15).
REQ-003 SHALL have parameter POLL_LIMIT, default 65535, maximum status polls per operation (1..65535).
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req, input, 1, operation request; sampled only in IDLE.
REQ-007 SHALL have port cmd, input, 2, operation select: 00 read, 01 program, 10 block erase, 11 reserved (completes with err).
REQ-008 SHALL have port addr, input, ADDR_W, word address; latched with req.
REQ-009 SHALL have port wdata, input, 16, program data; latched with req.
REQ-010 SHALL have port rdata, output, 16, registered read result.
REQ-011 SHALL have port busy, output, 1, high from the accept cycle until done.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1, error flag valid with done; held until next accept.
REQ-014 SHALL have port err_code, output, 2, 00 none, 01 program fail (SR4), 10 erase fail (SR5), 11 timeout/reserved cmd.
REQ-015 SHALL have port flash_addr, output, ADDR_W+1, {latched addr, 1'b0}.
REQ-016 SHALL have port flash_data, inout, 16, flash data bus.
REQ-017 SHALL have port flash_ctl, output, 8, {byte=1, ce, ce1=0, ce2=0, oe, rp=1, vpen=1, we}.

Function
REQ-018 SHALL accept in IDLE when req=1: latch addr/wdata/cmd, busy=1, clear err/err_code.
REQ-019 SHALL assert flash ce low whenever busy, high in IDLE.
REQ-020 SHALL drive flash_data from internal register when oe=1, high-Z when oe=0.
REQ-021 SHALL issue each bus write as: data set with we=0 one cycle, we=1 one cycle (two cycles per command word).
REQ-022 Read SHALL be: write 0x00FF, oe=0, wait READ_WAIT cycles, capture flash_data into rdata, oe=1, done; latency from accept to done = 4+READ_WAIT cycles.
REQ-023 Program SHALL be: write 0x0040, write latched wdata, then status poll.
REQ-024 Erase SHALL be: write 0x0020, write 0x00D0, then status poll.
REQ-025 Status poll SHALL be: write 0x0070, oe=0 one cycle, sample SR next cycle with oe=1; repeat until SR7=1.
REQ-026 On SR7=1 SHALL set err if SR4 (program) or SR5 (erase), then write 0x0050 (clear status) before done.
REQ-027 Reserved cmd SHALL produce done with err=1, err_code=11 two cycles after accept, no flash writes.
REQ-028 SHALL assert done exactly one cycle, returning to IDLE with busy=0 in that same cycle.
REQ-029 req while busy SHALL be ignored; req held high across done SHALL start a new op on the cycle after done.
REQ-030 Poll counter SHALL be 16 bits, cleared at accept, saturating, never wrapping.

Reset
REQ-031 rst SHALL immediately force IDLE, we=1, oe=1, ce=1, busy=0, done=0, err=0, err_code=00, rdata=0, poll counter=0, including mid-operation.
REQ-032 After rst deasserts, first accept SHALL occur no earlier than the next clk edge.

Configuration
REQ-033 With FLASH_CTRL_TIMEOUT_EN defined, SHALL abort polling when POLL_LIMIT polls complete without SR7: oe=1, we=1, done with err=1, err_code=11, no 0x0050.
REQ-034 Without FLASH_CTRL_TIMEOUT_EN, SHALL poll indefinitely; err_code 11 only for reserved cmd.

Verification
REQ-035 Read, READ_WAIT=4, addr=0x1234, model drives 0xBEEF -> flash_addr=0x2468, writes 0x00FF, rdata=0xBEEF, done 8 cycles after accept.
REQ-036 Program wdata=0xA5A5, model SR=0x80 on third poll -> bus writes 0x0040, 0xA5A5, three 0x0070, one 0x0050, done, err=0.
REQ-037 Erase, model SR=0xA0 -> writes 0x0020, 0x00D0, done with err=1, err_code=10.
REQ-038 FLASH_CTRL_TIMEOUT_EN, POLL_LIMIT=3, SR7 never set -> exactly 3 polls, done, err_code=11.
REQ-039 rst pulsed during erase poll -> same cycle we=1, oe=1, ce=1, busy=0; next req read completes normally.
REQ-040 cmd=11 with req held high -> done, err_code=11 after 2 cycles, next op accepted cycle after done.

Source files
------------

// File: rtl/flash_ctrl.sv
// Command sequencer for a 16-bit parallel NOR flash: read, word program and block erase.
// Define FLASH_CTRL_TIMEOUT_EN to abort status polling after POLL_LIMIT polls without SR7.
module flash_ctrl #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned READ_WAIT  = 4,
  parameter int unsigned POLL_LIMIT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   flash_addr,
  inout  wire  [15:0]       flash_data,
  output logic [7:0]        flash_ctl
);

`ifdef FLASH_CTRL_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [3:0]  WaitLast = 4'(READ_WAIT - 1);
  localparam logic [16:0] PollMax  = 17'(POLL_LIMIT);

  typedef enum logic [4:0] {
    StIdle, StRdCmdL, StRdCmdH, StRdWait, StRdEnd,
    StPgCmdL, StPgCmdH, StPgDatL, StPgDatH,
    StErCmdL, StErCmdH, StErCnfL, StErCnfH,
    StPlCmdL, StPlCmdH, StPlOe, StPlChk,
    StClrL, StClrH, StRsv
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              done_q, done_d;
  logic [15:0]       poll_cnt_q, poll_cnt_d;
  logic [3:0]        wait_q, wait_d;
  // Only SR7 (ready), SR5 (erase fail) and SR4 (program fail) matter.
  logic [2:0]        sr_q, sr_d;
  logic              limit_hit;
  logic              we, oe, ce;
  logic [15:0]       dout;

  assign limit_hit = ({1'b0, poll_cnt_q} + 17'd1) >= PollMax;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    poll_cnt_d = poll_cnt_q;
    wait_d     = wait_q;
    sr_d       = sr_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          cmd_d      = cmd;
          addr_d     = addr;
          wdata_d    = wdata;
          err_d      = 1'b0;
          err_code_d = 2'b00;
          poll_cnt_d = '0;
          case (cmd)
            2'b00:   state_d = StRdCmdL;
            2'b01:   state_d = StPgCmdL;
            2'b10:   state_d = StErCmdL;
            default: state_d = StRsv;
          endcase
        end
      end
      StRdCmdL: state_d = StRdCmdH;
      StRdCmdH: begin
        wait_d  = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (wait_q == WaitLast) begin
          rdata_d = flash_data;
          state_d = StRdEnd;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StRdEnd: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StPgCmdL: state_d = StPgCmdH;
      StPgCmdH: state_d = StPgDatL;
      StPgDatL: state_d = StPgDatH;
      StPgDatH: state_d = StPlCmdL;
      StErCmdL: state_d = StErCmdH;
      StErCmdH: state_d = StErCnfL;
      StErCnfL: state_d = StErCnfH;
      StErCnfH: state_d = StPlCmdL;
      StPlCmdL: state_d = StPlCmdH;
      StPlCmdH: state_d = StPlOe;
      StPlOe: begin
        sr_d    = {flash_data[7], flash_data[5], flash_data[4]};
        state_d = StPlChk;
      end
      StPlChk: begin
        if (poll_cnt_q != 16'hFFFF) poll_cnt_d = poll_cnt_q + 16'd1;
        if (sr_q[2]) begin
          if (cmd_q == 2'b01 && sr_q[0]) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (cmd_q == 2'b10 && sr_q[1]) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end
          state_d = StClrL;
        end else if (TimeoutEn && limit_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'b11;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else begin
          state_d = StPlCmdL;
        end
      end
      StClrL: state_d = StClrH;
      StClrH: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StRsv: begin
        err_d      = 1'b1;
        err_code_d = 2'b11;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      done_q     <= 1'b0;
      poll_cnt_q <= '0;
      wait_q     <= '0;
      sr_q       <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      poll_cnt_q <= poll_cnt_d;
      wait_q     <= wait_d;
      sr_q       <= sr_d;
    end
  end

  // Bus strobes decode straight from state so reset forces them inactive at once.
  always_comb begin
    we   = 1'b1;
    oe   = 1'b1;
    dout = 16'h0000;
    case (state_q)
      StRdCmdL: begin we = 1'b0; dout = 16'h00FF; end
      StRdCmdH: dout = 16'h00FF;
      StRdWait: oe = 1'b0;
      StPgCmdL: begin we = 1'b0; dout = 16'h0040; end
      StPgCmdH: dout = 16'h0040;
      StPgDatL: begin we = 1'b0; dout = wdata_q; end
      StPgDatH: dout = wdata_q;
      StErCmdL: begin we = 1'b0; dout = 16'h0020; end
      StErCmdH: dout = 16'h0020;
      StErCnfL: begin we = 1'b0; dout = 16'h00D0; end
      StErCnfH: dout = 16'h00D0;
      StPlCmdL: begin we = 1'b0; dout = 16'h0070; end
      StPlCmdH: dout = 16'h0070;
      StPlOe:   oe = 1'b0;
      StClrL:   begin we = 1'b0; dout = 16'h0050; end
      StClrH:   dout = 16'h0050;
      default:  ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign ce         = ~busy;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign rdata      = rdata_q;
  assign flash_addr = {addr_q, 1'b0};
  assign flash_data = oe ? dout : 16'hzzzz;
  assign flash_ctl  = {1'b1, ce, 1'b0, 1'b0, oe, 1'b1, 1'b1, we};

endmodule

// File: tb/tb_flash_ctrl.sv
// Directed bench for flash_ctrl with a small behavioural flash model on the shared data bus.
module tb_flash_ctrl;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [1:0]    cmd;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [AW:0]   flash_addr;
  wire  [15:0]   flash_data;
  logic [7:0]    flash_ctl;

  int checks = 0;
  int errors = 0;

  flash_ctrl #(
    .ADDR_W    (AW),
    .READ_WAIT (4),
    .POLL_LIMIT(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cmd       (cmd),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .flash_ctl (flash_ctl)
  );

  always #5 clk = ~clk;

  // Flash model: array read after 0x00FF, status register otherwise.
  logic [15:0] rd_val = 16'h0000;
  logic [7:0]  sr_final = 8'h00;
  int          ready_at = 1;
  int          polls_seen = 0;
  int          poll_base = 0;
  logic        mode_rd = 1'b0;
  logic        prev_oe = 1'b1;
  logic [15:0] model_val;
  logic [15:0] wlog[$];

  wire ce_n = flash_ctl[6];
  wire oe_n = flash_ctl[3];
  wire we_n = flash_ctl[0];

  always_comb begin
    model_val = 16'h0000;
    if (mode_rd) model_val = rd_val;
    else if (polls_seen - poll_base + 1 >= ready_at) model_val = {8'h00, sr_final};
  end

  assign flash_data = (!oe_n && !ce_n) ? model_val : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      wlog.push_back(flash_data);
      mode_rd <= (flash_data == 16'h00FF);
    end
    if (oe_n && !prev_oe && !mode_rd) polls_seen <= polls_seen + 1;
    prev_oe <= oe_n;
  end

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   rd_val;
    logic [7:0]    sr;
    int            ready_at;
    int            cycles;
    logic [15:0]   rdata;
    logic          err;
    logic [1:0]    code;
    int            nwr;
    logic [15:0]   w0;
    logic [15:0]   w1;
    int            npoll;
    int            nclr;
    logic [AW:0]   faddr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n;
    int start;
    int n70;
    int n50;
    @(negedge clk);
    cmd       = v.cmd;
    addr      = v.addr;
    wdata     = v.wdata;
    rd_val    = v.rd_val;
    sr_final  = v.sr;
    ready_at  = v.ready_at;
    poll_base = polls_seen;
    start     = wlog.size();
    req       = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk($sformatf("v%0d busy_at_accept", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d err_cleared", idx), 32'(err), 32'd0);
    chk($sformatf("v%0d ce_low", idx), 32'(flash_ctl[6]), 32'd0);
    chk($sformatf("v%0d ctl_fixed", idx), 32'(flash_ctl & 8'hB6), 32'h86);
    chk($sformatf("v%0d flash_addr", idx), 32'(flash_addr), 32'(v.faddr));
    n = 1;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d done_latency", idx), 32'(n), 32'(v.cycles));
    chk($sformatf("v%0d busy_at_done", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.rdata));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
    chk($sformatf("v%0d err_code", idx), 32'(err_code), 32'(v.code));
    n70 = 0;
    n50 = 0;
    for (int i = start; i < wlog.size(); i++) begin
      if (wlog[i] == 16'h0070) n70++;
      if (wlog[i] == 16'h0050) n50++;
    end
    chk($sformatf("v%0d n_writes", idx), 32'(wlog.size() - start), 32'(v.nwr));
    chk($sformatf("v%0d n_polls", idx), 32'(n70), 32'(v.npoll));
    chk($sformatf("v%0d n_clear", idx), 32'(n50), 32'(v.nclr));
    if (v.nwr >= 1 && wlog.size() > start)
      chk($sformatf("v%0d first_write", idx), 32'(wlog[start]), 32'(v.w0));
    if (v.nwr >= 2 && wlog.size() > start + 1)
      chk($sformatf("v%0d second_write", idx), 32'(wlog[start+1]), 32'(v.w1));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d err_held", idx), 32'(err), 32'(v.err));
  endtask

  initial begin
    int   n;
    int   start;
    vec_t v;
    //         cmd    addr         wdata     rd_val    sr     rdy cyc rdata     e  code nwr w0        w1        np nc faddr
    vecs[0] = '{2'd0, 22'h001234, 16'h0000, 16'hBEEF, 8'h00, 1,  8, 16'hBEEF, 0, 2'd0, 1, 16'h00FF, 16'h0000, 0, 0, 23'h002468};
    vecs[1] = '{2'd1, 22'h000010, 16'hA5A5, 16'h0000, 8'h80, 3, 19, 16'hBEEF, 0, 2'd0, 6, 16'h0040, 16'hA5A5, 3, 1, 23'h000020};
    vecs[2] = '{2'd2, 22'h000400, 16'h0000, 16'h0000, 8'hA0, 1, 11, 16'hBEEF, 1, 2'd2, 4, 16'h0020, 16'h00D0, 1, 1, 23'h000800};
    vecs[3] = '{2'd1, 22'h000001, 16'h1234, 16'h0000, 8'h90, 1, 11, 16'hBEEF, 1, 2'd1, 4, 16'h0040, 16'h1234, 1, 1, 23'h000002};
    vecs[4] = '{2'd2, 22'h000002, 16'h0000, 16'h0000, 8'h80, 2, 15, 16'hBEEF, 0, 2'd0, 5, 16'h0020, 16'h00D0, 2, 1, 23'h000004};
    vecs[5] = '{2'd3, 22'h000003, 16'h0000, 16'h0000, 8'h00, 1,  2, 16'hBEEF, 1, 2'd3, 0, 16'h0000, 16'h0000, 0, 0, 23'h000006};
    vecs[6] = '{2'd0, 22'h3FFFFF, 16'h0000, 16'h0001, 8'h00, 1,  8, 16'h0001, 0, 2'd0, 1, 16'h00FF, 16'h0000, 0, 0, 23'h7FFFFE};
    vecs[7] = '{2'd1, 22'h000005, 16'h5A5A, 16'h0000, 8'hB0, 1, 11, 16'h0001, 1, 2'd1, 4, 16'h0040, 16'h5A5A, 1, 1, 23'h00000A};
`ifdef FLASH_CTRL_TIMEOUT_EN
    vecs[8] = '{2'd1, 22'h000006, 16'hFFFF, 16'h0000, 8'h00, 100, 17, 16'h0001, 1, 2'd3, 5, 16'h0040, 16'hFFFF, 3, 0, 23'h00000C};
`else
    vecs[8] = '{2'd2, 22'h000006, 16'h0000, 16'h0000, 8'h80, 10, 47, 16'h0001, 0, 2'd0, 13, 16'h0020, 16'h00D0, 10, 1, 23'h00000C};
`endif

    rst   = 1'b1;
    req   = 1'b0;
    cmd   = 2'b00;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset err_code", 32'(err_code), 32'd0);
    chk("reset rdata", 32'(rdata), 32'd0);
    chk("reset flash_ctl", 32'(flash_ctl), 32'hCF);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(vecs[i], i);

    // Reset in the middle of an erase status poll.
    @(negedge clk);
    cmd       = 2'd2;
    addr      = 22'h000100;
    sr_final  = 8'h00;
    ready_at  = 1000;
    poll_base = polls_seen;
    req       = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst flash_ctl", 32'(flash_ctl), 32'hCF);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v = '{2'd0, 22'h000ABC, 16'h0000, 16'hCAFE, 8'h00, 1, 8, 16'hCAFE, 0, 2'd0, 1, 16'h00FF, 16'h0000, 0, 0, 23'h001578};
    run_op(v, 9);

    // Reserved command with req held high, then a read that ignores a request while busy.
    @(negedge clk);
    cmd    = 2'd3;
    addr   = 22'h000007;
    rd_val = 16'h1357;
    start  = wlog.size();
    req    = 1'b1;
    @(posedge clk);
    #1;
    chk("hold busy_rsv", 32'(busy), 32'd1);
    cmd = 2'd0;
    @(posedge clk);
    #1;
    chk("hold done_rsv", 32'(done), 32'd1);
    chk("hold busy_done", 32'(busy), 32'd0);
    chk("hold code_rsv", 32'(err_code), 32'd3);
    @(posedge clk);
    #1;
    chk("hold busy_next", 32'(busy), 32'd1);
    chk("hold done_next", 32'(done), 32'd0);
    chk("hold err_clear", 32'(err), 32'd0);
    req = 1'b0;
    n   = 1;
    @(posedge clk);
    #1;
    n++;
    req = 1'b1;
    cmd = 2'd2;
    @(posedge clk);
    #1;
    n++;
    req = 1'b0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold read_latency", 32'(n), 32'd8);
    chk("hold rdata", 32'(rdata), 32'h1357);
    chk("hold err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    chk("hold ignored_req", 32'(busy), 32'd0);
    chk("hold n_writes", 32'(wlog.size() - start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
